up5bit_count_monitor: RTL and testbench

- Registered checker sitting directly downstream of up5bit_counter; consumes its count output every valid cycle.
- Verifies each sample equals previous sample +1 (mod 2^WIDTH), locks onto the sequence, counts wrap-arounds and step errors, and raises a sticky fault after repeated consecutive errors.
- Used on-chip and in post-route benches as a self-check of counter netlists.

---
 rtl/up5bit_count_monitor.sv | 189 ++++++++++++++++++
 tb/tb_up5bit_count_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/up5bit_count_monitor.sv
// ---------------------------------------------------------------------------
// up5bit_count_monitor
//
// Purpose:
//   Registered checker placed directly downstream of an up-counter. Every
//   valid sample must equal the previous sample plus one (mod 2^WIDTH).
//   The monitor first acquires the sequence, then locks onto it. While
//   locked it counts step errors and wrap-arounds. After FAULT_LIMIT
//   consecutive step errors it raises a sticky fault.
//
// Parameters:
//   WIDTH        width of the monitored count
//   SYNC_LEN     consecutive correct steps needed to lock (1..15)
//   FAULT_LIMIT  consecutive locked step errors that trigger fault (1..15)
//   STAT_W       width of the saturating statistics counters
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   count_in     counter value under test
//   count_valid  count_in is sampled only when this is 1
//   clr_stats    clears statistics and fault; leaves lock state alone
//   locked       1 while in LOCKED
//   fault        1 while in FAULT (sticky)
//   step_err     one-cycle pulse per detected step error
//   wrap_pulse   one-cycle pulse per correct max->0 step
//   err_count    saturating step-error total
//   wrap_count   saturating wrap total
// ---------------------------------------------------------------------------
module up5bit_count_monitor #(
    parameter int WIDTH       = 5,
    parameter int SYNC_LEN    = 2,
    parameter int FAULT_LIMIT = 4,
    parameter int STAT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic              clr_stats,
    output logic              locked,
    output logic              fault,
    output logic              step_err,
    output logic              wrap_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [3:0]        SYNC_TARGET  = 4'(SYNC_LEN);
    localparam logic [3:0]        FAULT_TARGET = 4'(FAULT_LIMIT);
    localparam logic [WIDTH-1:0]  COUNT_MAX    = {WIDTH{1'b1}};
    localparam logic [STAT_W-1:0] STAT_MAX     = {STAT_W{1'b1}};

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  prev, prev_nxt;
    logic [3:0]        good_run, good_run_nxt;
    logic [3:0]        bad_run, bad_run_nxt;
    logic              step_err_nxt;
    logic              wrap_pulse_nxt;
    logic [STAT_W-1:0] err_count_nxt;
    logic [STAT_W-1:0] wrap_count_nxt;

    logic              correct;
    logic              is_wrap;
    logic [3:0]        good_inc;
    logic [3:0]        bad_inc;

    // Step classification against the last accepted sample. The sum is
    // truncated to WIDTH bits so max->0 counts as a correct step.
    assign correct  = (count_in == prev + WIDTH'(1));
    assign is_wrap  = correct && (prev == COUNT_MAX);
    assign good_inc = good_run + 4'd1;
    assign bad_inc  = bad_run + 4'd1;

    // Next-state logic: state transitions, run counters, pulses and the
    // saturating statistics. clr_stats is applied last so it overrides any
    // same-cycle increment while still letting prev follow the sample.
    always_comb begin
        state_nxt      = state;
        prev_nxt       = prev;
        good_run_nxt   = good_run;
        bad_run_nxt    = bad_run;
        step_err_nxt   = 1'b0;
        wrap_pulse_nxt = 1'b0;
        err_count_nxt  = err_count;
        wrap_count_nxt = wrap_count;

        if (count_valid) begin
            prev_nxt = count_in;
            case (state)
                IDLE: begin
                    state_nxt    = ACQUIRE;
                    good_run_nxt = 4'd0;
                end
                ACQUIRE: begin
                    if (correct) begin
                        wrap_pulse_nxt = is_wrap;
                        if (good_inc >= SYNC_TARGET) begin
                            state_nxt    = LOCKED;
                            good_run_nxt = 4'd0;
                            bad_run_nxt  = 4'd0;
                        end else begin
                            good_run_nxt = good_inc;
                        end
                    end else begin
                        good_run_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (correct) begin
                        bad_run_nxt    = 4'd0;
                        wrap_pulse_nxt = is_wrap;
                    end else begin
                        step_err_nxt = 1'b1;
                        bad_run_nxt  = bad_inc;
                        if (bad_inc >= FAULT_TARGET) begin
                            state_nxt = FAULT;
                        end
                    end
                end
                FAULT: begin
                    step_err_nxt = !correct;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            if (step_err_nxt && (err_count != STAT_MAX)) begin
                err_count_nxt = err_count + STAT_W'(1);
            end
            if (wrap_pulse_nxt && (wrap_count != STAT_MAX)) begin
                wrap_count_nxt = wrap_count + STAT_W'(1);
            end
        end

        // With bad_run cleared, an error that would have tipped LOCKED into
        // FAULT in the same cycle no longer does so; lock is kept.
        if (clr_stats) begin
            err_count_nxt  = '0;
            wrap_count_nxt = '0;
            bad_run_nxt    = 4'd0;
            step_err_nxt   = 1'b0;
            wrap_pulse_nxt = 1'b0;
            if (state == FAULT) begin
                state_nxt    = ACQUIRE;
                good_run_nxt = 4'd0;
            end else if (state_nxt == FAULT) begin
                state_nxt = LOCKED;
            end
        end
    end

    // State and output registers; locked/fault are registered copies of the
    // next state so every output is driven straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            good_run   <= 4'd0;
            bad_run    <= 4'd0;
            locked     <= 1'b0;
            fault      <= 1'b0;
            step_err   <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            good_run   <= good_run_nxt;
            bad_run    <= bad_run_nxt;
            locked     <= (state_nxt == LOCKED);
            fault      <= (state_nxt == FAULT);
            step_err   <= step_err_nxt;
            wrap_pulse <= wrap_pulse_nxt;
            err_count  <= err_count_nxt;
            wrap_count <= wrap_count_nxt;
        end
    end

endmodule

// File: tb/tb_up5bit_count_monitor.sv
// ---------------------------------------------------------------------------
// tb_up5bit_count_monitor
//
// Purpose:
//   Directed bench for up5bit_count_monitor with default parameters
//   (WIDTH=5, SYNC_LEN=2, FAULT_LIMIT=4, STAT_W=8). Expected values are
//   worked out by hand for each step of the sequence.
// ---------------------------------------------------------------------------
module tb_up5bit_count_monitor;

    logic       clk;
    logic       reset;
    logic [4:0] count_in;
    logic       count_valid;
    logic       clr_stats;
    logic       locked;
    logic       fault;
    logic       step_err;
    logic       wrap_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int total;
    int bad;

    up5bit_count_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .clr_stats   (clr_stats),
        .locked      (locked),
        .fault       (fault),
        .step_err    (step_err),
        .wrap_pulse  (wrap_pulse),
        .err_count   (err_count),
        .wrap_count  (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs on the falling edge, then wait until just
    // after the rising edge so the registered response can be sampled.
    task automatic applyStimulus(input logic rst, input logic vld,
                                 input logic [4:0] val, input logic clr);
        @(negedge clk);
        reset       = rst;
        count_valid = vld;
        count_in    = val;
        clr_stats   = clr;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic e_locked,
                               input logic e_fault, input logic e_step,
                               input logic e_wrap, input logic [7:0] e_err,
                               input logic [7:0] e_wrapc);
        total += 6;
        assert (locked === e_locked) else begin
            bad++;
            $error("[TB] FAIL %s locked got=%0b exp=%0b", tag, locked, e_locked);
        end
        assert (fault === e_fault) else begin
            bad++;
            $error("[TB] FAIL %s fault got=%0b exp=%0b", tag, fault, e_fault);
        end
        assert (step_err === e_step) else begin
            bad++;
            $error("[TB] FAIL %s step_err got=%0b exp=%0b", tag, step_err, e_step);
        end
        assert (wrap_pulse === e_wrap) else begin
            bad++;
            $error("[TB] FAIL %s wrap_pulse got=%0b exp=%0b", tag, wrap_pulse, e_wrap);
        end
        assert (err_count === e_err) else begin
            bad++;
            $error("[TB] FAIL %s err_count got=%0d exp=%0d", tag, err_count, e_err);
        end
        assert (wrap_count === e_wrapc) else begin
            bad++;
            $error("[TB] FAIL %s wrap_count got=%0d exp=%0d", tag, wrap_count, e_wrapc);
        end
    endtask

    initial begin
        logic [4:0] v;
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        count_valid = 1'b0;
        count_in    = '0;
        clr_stats   = 1'b0;

        // Reset wins over a valid sample presented at the same time.
        applyStimulus(1, 0, 5'd0, 0);
        applyStimulus(1, 1, 5'd7, 1);
        checkOutput("reset", 0, 0, 0, 0, 8'd0, 8'd0);

        // Acquire and lock on 0,1,2,3.
        applyStimulus(0, 1, 5'd0, 0);
        checkOutput("acq_s0", 0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd1, 0);
        checkOutput("acq_s1", 0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd2, 0);
        checkOutput("lock_s2", 1, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd3, 0);
        checkOutput("lock_s3", 1, 0, 0, 0, 8'd0, 8'd0);

        // Run up to the wrap point.
        for (int i = 4; i <= 31; i++) begin
            applyStimulus(0, 1, 5'(i), 0);
            checkOutput("run_to_wrap", 1, 0, 0, 0, 8'd0, 8'd0);
        end
        applyStimulus(0, 1, 5'd0, 0);
        checkOutput("wrap_31_0", 1, 0, 0, 1, 8'd0, 8'd1);
        applyStimulus(0, 1, 5'd1, 0);
        checkOutput("after_wrap", 1, 0, 0, 0, 8'd0, 8'd1);

        // Up to 10, then a repeat and a skip; resync means 14 is correct.
        for (int i = 2; i <= 10; i++) begin
            applyStimulus(0, 1, 5'(i), 0);
        end
        applyStimulus(0, 1, 5'd10, 0);
        checkOutput("err_repeat10", 1, 0, 1, 0, 8'd1, 8'd1);
        applyStimulus(0, 1, 5'd13, 0);
        checkOutput("err_skip13", 1, 0, 1, 0, 8'd2, 8'd1);
        applyStimulus(0, 1, 5'd14, 0);
        checkOutput("resync14", 1, 0, 0, 0, 8'd2, 8'd1);
        applyStimulus(0, 1, 5'd15, 0);
        checkOutput("ok15", 1, 0, 0, 0, 8'd2, 8'd1);

        // Clear statistics while locked, then four consecutive errors.
        applyStimulus(0, 0, 5'd0, 1);
        checkOutput("clr_locked", 1, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd5, 0);
        checkOutput("bad1", 1, 0, 1, 0, 8'd1, 8'd0);
        applyStimulus(0, 1, 5'd9, 0);
        checkOutput("bad2", 1, 0, 1, 0, 8'd2, 8'd0);
        applyStimulus(0, 1, 5'd2, 0);
        checkOutput("bad3", 1, 0, 1, 0, 8'd3, 8'd0);
        applyStimulus(0, 1, 5'd20, 0);
        checkOutput("bad4_fault", 0, 1, 1, 0, 8'd4, 8'd0);
        applyStimulus(0, 1, 5'd21, 0);
        checkOutput("fault_ok21", 0, 1, 0, 0, 8'd4, 8'd0);
        applyStimulus(0, 1, 5'd22, 0);
        checkOutput("fault_ok22", 0, 1, 0, 0, 8'd4, 8'd0);
        applyStimulus(0, 1, 5'd7, 0);
        checkOutput("fault_bad7", 0, 1, 1, 0, 8'd5, 8'd0);
        applyStimulus(0, 0, 5'd0, 1);
        checkOutput("clr_fault", 0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd8, 0);
        checkOutput("reacq8", 0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd9, 0);
        checkOutput("relock9", 1, 0, 0, 0, 8'd0, 8'd0);

        // Invalid cycles carry garbage; prev must hold across them.
        for (int i = 10; i <= 25; i++) begin
            applyStimulus(0, 0, 5'($urandom_range(31)), 0);
            checkOutput("gap_invalid", 1, 0, 0, 0, 8'd0, 8'd0);
            applyStimulus(0, 1, 5'(i), 0);
            checkOutput("gap_valid", 1, 0, 0, 0, 8'd0, 8'd0);
        end

        // 9600 correct samples starting at 26 give 300 wraps; count saturates.
        v = 5'd26;
        for (int n = 0; n < 300 * 32; n++) begin
            applyStimulus(0, 1, v, 0);
            v = v + 5'd1;
        end
        checkOutput("wrap_saturate", 1, 0, 0, 0, 8'd0, 8'd255);

        // Three repeated samples in a row: three errors, still locked.
        v = v - 5'd1;
        applyStimulus(0, 0, 5'd0, 1);
        applyStimulus(0, 1, v, 0);
        applyStimulus(0, 1, v, 0);
        applyStimulus(0, 1, v, 0);
        checkOutput("three_errs", 1, 0, 1, 0, 8'd3, 8'd0);

        // Reset mid-lock, then the upstream counter restarts from 0.
        applyStimulus(1, 1, 5'd0, 0);
        checkOutput("reset_midlock", 0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd0, 0);
        checkOutput("restart0", 0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd1, 0);
        checkOutput("restart1", 0, 0, 0, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 5'd2, 0);
        checkOutput("restart_lock", 1, 0, 0, 0, 8'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
